// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state
// encoding and the default memory-wait timeout.
package lsu_pkg;

  localparam int XLEN = 32;

  // RV32I load/store width encodings.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Default cycles to wait for grant / read data when the timeout is built in.
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/lsu_if.sv
// Bundle of the LSU request, data-memory and response signals.
// slave = the LSU side; master = the pipeline plus memory around it.
interface lsu_if
  import lsu_pkg::*;
();

  // Request from the execute stage.
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [4:0]      req_rd;

  // Data-memory port.
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_wstrb;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  // Completion to writeback.
  logic            rsp_valid;
  logic [4:0]      rsp_rd;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;
  logic            busy;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output rsp_valid, rsp_rd, rsp_rdata, rsp_err, busy
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  rsp_valid, rsp_rd, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational alignment helpers for the LSU: store lane replication and
// byte strobes, misaligned/illegal request detection, and load
// extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  // Incoming request (store lanes and legality check).
  input  logic [2:0]      i_req_funct3,
  input  logic            i_req_we,
  input  logic [1:0]      i_req_addr_lo,
  input  logic [XLEN-1:0] i_req_wdata,
  // Latched load context plus the returned memory word.
  input  logic [2:0]      i_ld_funct3,
  input  logic [1:0]      i_ld_addr_lo,
  input  logic [XLEN-1:0] i_ld_rdata,
  output logic [XLEN-1:0] o_st_wdata,
  output logic [3:0]      o_st_wstrb,
  output logic            o_req_err,
  output logic [XLEN-1:0] o_ld_data
);

  logic       w_misaligned;
  logic       w_illegal;
  logic [7:0] w_byte;
  logic [15:0] w_half;

  // Store data replication across lanes and strobe generation.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    o_st_wdata = i_req_wdata;
    o_st_wstrb = 4'b0000;
    case (i_req_funct3)
      F3_B: begin
        o_st_wdata = {4{i_req_wdata[7:0]}};
        o_st_wstrb = 4'b0001 << i_req_addr_lo;
      end
      F3_H: begin
        o_st_wdata = {2{i_req_wdata[15:0]}};
        o_st_wstrb = 4'b0011 << i_req_addr_lo;
      end
      F3_W: o_st_wstrb = 4'b1111;
      default: o_st_wstrb = 4'b0000;
    endcase
  end

  // Misaligned / illegal request classification.
  always_comb begin
    w_misaligned = 1'b0;
    w_illegal    = 1'b0;
    case (i_req_funct3)
      F3_B:  w_illegal = 1'b0;
      F3_BU: w_illegal = i_req_we;
      F3_H:  w_misaligned = i_req_addr_lo[0];
      F3_HU: begin
        w_misaligned = i_req_addr_lo[0];
        w_illegal    = i_req_we;
      end
      F3_W:  w_misaligned = |i_req_addr_lo;
      default: w_illegal = 1'b1;
    endcase
    o_req_err = w_misaligned | w_illegal;
  end

  // Load extraction from the returned word and extension to XLEN.
  always_comb begin
    case (i_ld_addr_lo)
      2'd0:    w_byte = i_ld_rdata[7:0];
      2'd1:    w_byte = i_ld_rdata[15:8];
      2'd2:    w_byte = i_ld_rdata[23:16];
      default: w_byte = i_ld_rdata[31:24];
    endcase
    w_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ld_data = {24'h000000, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ld_data = {16'h0000, w_half};
      F3_W:    o_ld_data = i_ld_rdata;
      default: o_ld_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one RV32I load/store at a time, runs a single
// request/grant/response transaction on the data-memory port and returns
// aligned, extended load data (or store completion) to writeback.
// Optional build macro LSU_TIMEOUT_EN: abort a memory wait with rsp_err
// after TIMEOUT_CYCLES cycles without grant / read data.
module lsu
  import lsu_pkg::*;
#(
  parameter int WIDTH          = XLEN,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  lsu_if.slave  bus
);

  // Only a 32-bit datapath exists, and the timeout needs at least two states.
  if (WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("lsu: unsupported WIDTH or TIMEOUT_CYCLES");
  end

  state_e          r_state;
  logic            r_req_ready;
  logic            r_busy;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addr_lo;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [3:0]      r_mem_wstrb;
  logic [XLEN-1:0] r_mem_wdata;
  logic            r_rsp_valid;
  logic [4:0]      r_rsp_rd;
  logic [XLEN-1:0] r_rsp_rdata;
  logic            r_rsp_err;

  logic            w_accept;
  logic            w_req_err;
  logic [XLEN-1:0] w_st_wdata;
  logic [3:0]      w_st_wstrb;
  logic [XLEN-1:0] w_ld_data;
  logic            w_tmo_hit;

  assign w_accept = bus.req_valid && r_req_ready;

  lsu_align u_align (
    .i_req_funct3  (bus.req_funct3),
    .i_req_we      (bus.req_we),
    .i_req_addr_lo (bus.req_addr[1:0]),
    .i_req_wdata   (bus.req_wdata),
    .i_ld_funct3   (r_funct3),
    .i_ld_addr_lo  (r_addr_lo),
    .i_ld_rdata    (bus.mem_rdata),
    .o_st_wdata    (w_st_wdata),
    .o_st_wstrb    (w_st_wstrb),
    .o_req_err     (w_req_err),
    .o_ld_data     (w_ld_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] r_tmo_cnt;

  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Wait counter: runs while a grant or read response is outstanding,
  // cleared on every other cycle so each wait phase starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == REQ && !bus.mem_gnt) ||
                 (r_state == WAIT_R && !bus.mem_rvalid)) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Transaction FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled here on the clock edge (synchronous) and also
    // clears the datapath registers so every output is defined after reset.
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wstrb <= 4'b0000;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rd    <= 5'd0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we        <= bus.req_we;
            r_funct3    <= bus.req_funct3;
            r_addr_lo   <= bus.req_addr[1:0];
            r_rsp_rd    <= bus.req_rd;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (w_req_err) begin
              // Rejected without touching memory.
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_state     <= REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= bus.req_we;
              r_mem_addr  <= {bus.req_addr[XLEN-1:2], 2'b00};
              r_mem_wstrb <= bus.req_we ? w_st_wstrb : 4'b0000;
              r_mem_wdata <= bus.req_we ? w_st_wdata : '0;
            end
          end
        end

        REQ: begin
          if (bus.mem_gnt) begin
            r_mem_req <= 1'b0;
            if (r_we) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
              r_rsp_rdata <= '0;
            end else begin
              r_state <= WAIT_R;
            end
          end else if (w_tmo_hit) begin
            r_mem_req   <= 1'b0;
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end
        end

        WAIT_R: begin
          // Read data only counts once the grant cycle is over.
          if (bus.mem_rvalid) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= w_ld_data;
          end else if (w_tmo_hit) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end
        end

        RESP: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end

        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_mem_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.busy      = r_busy;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rd    = r_rsp_rd;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule
